hold_repeat_counter: RTL and testbench

Parametrised up/down counter driven by held direction inputs such as debounced push-buttons, with key-style auto-repeat. It steps once on press, steps again after a first delay, then keeps stepping at a separate repeat rate while the input is held. Range is programmable (min/max), and the limit mode is selectable: wrap or saturate. The block sits between the input conditioning logic and the display/value registers of lab designs.

---
 rtl/hold_repeat_counter.sv | 151 +++++++++++++++
 tb/tb_hold_repeat_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hold_repeat_counter.sv
// Up/down counter stepped by held direction inputs, with key-style auto-repeat
// (press step, first delay, then repeat rate) and wrap or saturate at bounds.
module hold_repeat_counter #(
  parameter int WIDTH   = 16,
  parameter int DLY_W   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [DLY_W-1:0] first_delay,
  input  logic [DLY_W-1:0] repeat_delay,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             wrapped,
  output logic             limit_hit,
  output logic             dir
);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             wrap_q, wrap_d;
  logic             limit_q, limit_d;
  logic             dir_q, dir_d;

  logic req_up, req_dn, req, do_step, step_dir, range_bad;

  assign req_up    = up & ~down;
  assign req_dn    = down & ~up;
  assign req       = req_up | req_dn;
  assign range_bad = min_val > max_val;

  // Sequencing: decides whether this cycle steps and in which direction.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    do_step  = 1'b0;
    step_dir = req_up;
    if (load) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            do_step = 1'b1;
            state_d = FIRST;
            timer_d = '0;
          end
        end
        default: begin
          if (!req) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (req_up != dir_q) begin
            // Reversal behaves like a fresh press.
            do_step = 1'b1;
            state_d = FIRST;
            timer_d = '0;
          end else if (timer_q == ((state_q == FIRST) ? first_delay : repeat_delay)) begin
            do_step = 1'b1;
            state_d = REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Value update: load clamp, or step rules in priority order.
  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    wrap_d  = 1'b0;
    limit_d = 1'b0;
    dir_d   = dir_q;
    if (load) begin
      if (range_bad)              count_d = load_val;
      else if (load_val < min_val) count_d = min_val;
      else if (load_val > max_val) count_d = max_val;
      else                         count_d = load_val;
    end else if (do_step) begin
      dir_d = step_dir;
      if (range_bad) begin
        count_d = count_q;
      end else if (count_q < min_val) begin
        count_d = min_val;
        pulse_d = 1'b1;
      end else if (count_q > max_val) begin
        count_d = max_val;
        pulse_d = 1'b1;
      end else if (step_dir && count_q == max_val) begin
        if (saturate) limit_d = 1'b1;
        else begin
          count_d = min_val;
          pulse_d = 1'b1;
          wrap_d  = 1'b1;
        end
      end else if (!step_dir && count_q == min_val) begin
        if (saturate) limit_d = 1'b1;
        else begin
          count_d = max_val;
          pulse_d = 1'b1;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = step_dir ? count_q + 1'b1 : count_q - 1'b1;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= RST_VAL;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
      limit_q <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
    end
  end

  assign count      = count_q;
  assign step_pulse = pulse_q;
  assign wrapped    = wrap_q;
  assign limit_hit  = limit_q;
  assign dir        = dir_q;

endmodule

// File: tb/tb_hold_repeat_counter.sv
// Directed bench for hold_repeat_counter: timing, wrap, saturate, flip, load, range cases.
module tb_hold_repeat_counter;
  localparam int WIDTH = 16;
  localparam int DLY_W = 32;

  logic             clk = 0;
  logic             rst, up, down, load, saturate;
  logic [WIDTH-1:0] load_val, min_val, max_val, count;
  logic [DLY_W-1:0] first_delay, repeat_delay;
  logic             step_pulse, wrapped, limit_hit, dir;
  int checks = 0, errors = 0;

  hold_repeat_counter #(.WIDTH(WIDTH), .DLY_W(DLY_W), .RST_VAL(16'd0)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .load(load), .load_val(load_val),
    .min_val(min_val), .max_val(max_val), .first_delay(first_delay),
    .repeat_delay(repeat_delay), .saturate(saturate), .count(count),
    .step_pulse(step_pulse), .wrapped(wrapped), .limit_hit(limit_hit), .dir(dir));

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1; load_val = v; tick(); load = 0;
  endtask

  task automatic cfg(input int mn, input int mx, input int fd, input int rd, input logic s);
    min_val = mn[WIDTH-1:0]; max_val = mx[WIDTH-1:0];
    first_delay = fd[DLY_W-1:0]; repeat_delay = rd[DLY_W-1:0]; saturate = s;
  endtask

  task automatic test_reset();
    rst = 1; up = 0; down = 0; load = 0; load_val = 0;
    cfg(0, 100, 9, 2, 0);
    tick(); tick();
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({step_pulse, wrapped, limit_hit} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {step_pulse, wrapped, limit_hit}); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", dir); end
    rst = 0; tick();
  endtask

  task automatic test_press_timing();
    int exp_c;
    logic exp_p;
    cfg(0, 100, 9, 2, 0);
    do_load(16'd5);
    exp_c = 5;
    up = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_p = (c == 0 || c == 10 || c == 13 || c == 16 || c == 19);
      if (exp_p) exp_c++;
      checks++; if (count !== exp_c[WIDTH-1:0]) begin errors++; $display("FAIL press_count cyc %0d got %0d want %0d", c, count, exp_c); end
      checks++; if (step_pulse !== exp_p) begin errors++; $display("FAIL press_pulse cyc %0d got %b want %b", c, step_pulse, exp_p); end
    end
    up = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (count !== 16'd10 || step_pulse !== 1'b0) begin errors++; $display("FAIL release cyc %0d got %0d/%b want 10/0", c, count, step_pulse); end
    end
  endtask

  task automatic test_wrap();
    cfg(3, 7, 9, 2, 0);
    do_load(16'd7);
    up = 1; tick();
    checks++; if ({count, step_pulse, wrapped} !== {16'd3, 2'b11}) begin errors++; $display("FAIL wrap_up got %0d p%b w%b want 3 p1 w1", count, step_pulse, wrapped); end
    up = 0; tick();
    checks++; if (wrapped !== 1'b0 || step_pulse !== 1'b0) begin errors++; $display("FAIL wrap_width got p%b w%b want 0 0", step_pulse, wrapped); end
    down = 1; tick();
    checks++; if ({count, step_pulse, wrapped} !== {16'd7, 2'b11}) begin errors++; $display("FAIL wrap_dn got %0d p%b w%b want 7 p1 w1", count, step_pulse, wrapped); end
    down = 0; tick();
  endtask

  task automatic test_saturate();
    logic exp_l;
    int hits = 0;
    cfg(3, 7, 9, 2, 1);
    do_load(16'd7);
    up = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      exp_l = (c == 0 || c == 10 || (c > 10 && (c - 10) % 3 == 0));
      if (limit_hit) hits++;
      checks++; if (count !== 16'd7 || step_pulse !== 1'b0 || limit_hit !== exp_l) begin
        errors++; $display("FAIL sat cyc %0d got c%0d p%b l%b want c7 p0 l%b", c, count, step_pulse, limit_hit, exp_l); end
    end
    up = 0; tick();
    checks++; if (hits != 8) begin errors++; $display("FAIL sat_hits got %0d want 8", hits); end
  endtask

  task automatic test_dir_flip();
    cfg(0, 100, 3, 1, 0);
    do_load(16'd50);
    up = 1;
    for (int c = 0; c < 7; c++) tick();
    checks++; if (count !== 16'd53 || dir !== 1'b1) begin errors++; $display("FAIL flip_pre got %0d d%b want 53 d1", count, dir); end
    up = 0; down = 1; tick();
    checks++; if (count !== 16'd52 || step_pulse !== 1'b1 || dir !== 1'b0) begin errors++; $display("FAIL flip_step got %0d p%b d%b want 52 p1 d0", count, step_pulse, dir); end
    tick(); tick(); tick();
    checks++; if (count !== 16'd52) begin errors++; $display("FAIL flip_wait got %0d want 52", count); end
    tick();
    checks++; if (count !== 16'd51 || step_pulse !== 1'b1) begin errors++; $display("FAIL flip_first got %0d p%b want 51 p1", count, step_pulse); end
    up = 1; down = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (count !== 16'd51 || step_pulse !== 1'b0) begin errors++; $display("FAIL both cyc %0d got %0d p%b want 51 p0", c, count, step_pulse); end
    end
    up = 0; down = 1; tick();
    checks++; if (count !== 16'd50 || step_pulse !== 1'b1) begin errors++; $display("FAIL both_idle got %0d p%b want 50 p1", count, step_pulse); end
    down = 0; tick();
  endtask

  task automatic test_load();
    cfg(0, 100, 0, 0, 0);
    do_load(16'd200);
    checks++; if (count !== 16'd100 || step_pulse !== 1'b0) begin errors++; $display("FAIL load_clamp got %0d p%b want 100 p0", count, step_pulse); end
    do_load(16'd10);
    up = 1; tick(); tick(); tick();
    checks++; if (count !== 16'd13) begin errors++; $display("FAIL fast_rep got %0d want 13", count); end
    load = 1; load_val = 16'd40; tick(); load = 0;
    checks++; if (count !== 16'd40 || step_pulse !== 1'b0) begin errors++; $display("FAIL load_prio got %0d p%b want 40 p0", count, step_pulse); end
    tick();
    checks++; if (count !== 16'd41 || step_pulse !== 1'b1) begin errors++; $display("FAIL load_repress got %0d p%b want 41 p1", count, step_pulse); end
    up = 0; tick();
  endtask

  task automatic test_range();
    cfg(0, 100, 9, 2, 0);
    do_load(16'd50);
    max_val = 16'd20;
    down = 1; tick();
    checks++; if (count !== 16'd20 || step_pulse !== 1'b1 || wrapped !== 1'b0) begin errors++; $display("FAIL oor got %0d p%b w%b want 20 p1 w0", count, step_pulse, wrapped); end
    down = 0; tick();
    cfg(9, 4, 9, 2, 0);
    do_load(16'd6);
    checks++; if (count !== 16'd6) begin errors++; $display("FAIL bad_load got %0d want 6", count); end
    up = 1; tick();
    checks++; if (count !== 16'd6 || {step_pulse, wrapped, limit_hit} !== 3'b000 || dir !== 1'b1) begin errors++; $display("FAIL bad_up got %0d %b d%b want 6 000 d1", count, {step_pulse, wrapped, limit_hit}, dir); end
    up = 0; tick(); down = 1; tick();
    checks++; if (count !== 16'd6 || {step_pulse, wrapped, limit_hit} !== 3'b000 || dir !== 1'b0) begin errors++; $display("FAIL bad_dn got %0d %b d%b want 6 000 d0", count, {step_pulse, wrapped, limit_hit}, dir); end
    down = 0; tick();
  endtask

  task automatic test_reset_mid_hold();
    cfg(0, 100, 1, 1, 0);
    do_load(16'd30);
    up = 1; tick(); tick(); tick();
    rst = 1; tick();
    checks++; if (count !== 16'd0 || step_pulse !== 1'b0 || dir !== 1'b1) begin errors++; $display("FAIL rst_hold got %0d p%b d%b want 0 p0 d1", count, step_pulse, dir); end
    rst = 0; tick();
    checks++; if (count !== 16'd1 || step_pulse !== 1'b1) begin errors++; $display("FAIL rst_repress got %0d p%b want 1 p1", count, step_pulse); end
    up = 0; tick();
  endtask

  initial begin
    test_reset();
    test_press_timing();
    test_wrap();
    test_saturate();
    test_dir_flip();
    test_load();
    test_range();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
